// File: rtl/cpu_core_p.sv
// cpu_core_p: small multi-cycle accumulator-style core.
// Two-state instruction cycle (FETCH -> EXEC) with a sticky HALT state,
// NREG general registers of DW bits and a 4-bit status register {V,N,C,Z}.
module cpu_core_p #(
  parameter int DW   = 8,
  parameter int AW   = 16,
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [15:0]   imem_data,
  output logic [3:0]    sreg,
  output logic          halted,
  input  logic [3:0]    dbg_idx,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_COM  = 4'h1,
    OP_BRNE = 4'h2,
    OP_HALT = 4'h3,
    OP_NEG  = 4'h4,
    OP_INC  = 4'h5,
    OP_LSR  = 4'h6,
    OP_LSL  = 4'h7,
    OP_MOV  = 4'h8,
    OP_LDI  = 4'h9,
    OP_ADD  = 4'hA,
    OP_ADC  = 4'hB,
    OP_AND  = 4'hC,
    OP_OR   = 4'hD,
    OP_BREQ = 4'hE,
    OP_RJMP = 4'hF
  } op_e;

  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  // Architectural and control state
  state_e        state_q, state_d;
  logic          started_q, started_d;
  logic [AW-1:0] ip_q, ip_d;
  logic [15:0]   ir_q, ir_d;
  logic [3:0]    sreg_q, sreg_d;
  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  // Instruction fields
  op_e           op;
  logic [3:0]    rd_idx;
  logic [3:0]    rs_idx;
  logic [7:0]    imm8;

  // Datapath results
  logic [DW-1:0] rd_val;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] res;
  logic [DW:0]   sum;
  logic          cin;
  logic          wr_en;
  logic          upd_nz;
  logic          c_new;
  logic          v_new;
  logic          z_new;
  logic          n_new;
  logic          br_taken;
  logic [3:0]    sreg_new;
  logic [AW-1:0] ip_next;

  assign op     = op_e'(ir_q[15:12]);
  assign rd_idx = ir_q[11:8];
  assign rs_idx = ir_q[3:0];
  assign imm8   = ir_q[7:0];

  // Operand read; indices beyond NREG read as zero
  always_comb begin
    rd_val = '0;
    rs_val = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (rd_idx == 4'(i)) rd_val = regs_q[i];
      if (rs_idx == 4'(i)) rs_val = regs_q[i];
    end
  end

  // Shared (DW+1)-bit adder for ADD/ADC; carry-out lands in bit DW
  always_comb begin
    cin = (op == OP_ADC) & sreg_q[1];
    sum = {1'b0, rd_val} + {1'b0, rs_val} + (DW+1)'(cin);
  end

  // ALU: result, write enable, flag updates and branch decision
  always_comb begin
    res      = '0;
    wr_en    = 1'b0;
    upd_nz   = 1'b0;
    c_new    = sreg_q[1];
    v_new    = sreg_q[3];
    br_taken = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_COM: begin
        res    = ~rd_val;
        wr_en  = 1'b1;
        upd_nz = 1'b1;
        c_new  = 1'b1;
        v_new  = 1'b0;
      end
      OP_BRNE: br_taken = ~sreg_q[0];
      OP_HALT: ;
      OP_NEG: begin
        res    = '0 - rd_val;
        wr_en  = 1'b1;
        upd_nz = 1'b1;
        c_new  = (res != '0);
        v_new  = (rd_val == MIN_NEG);
      end
      OP_INC: begin
        res    = rd_val + DW'(1);
        wr_en  = 1'b1;
        upd_nz = 1'b1;
        v_new  = (rd_val == MAX_POS);
      end
      OP_LSR: begin
        res    = rd_val >> 1;
        wr_en  = 1'b1;
        upd_nz = 1'b1;
        c_new  = rd_val[0];
        v_new  = 1'b0;
      end
      OP_LSL: begin
        res    = rd_val << 1;
        wr_en  = 1'b1;
        upd_nz = 1'b1;
        c_new  = rd_val[DW-1];
        v_new  = 1'b0;
      end
      OP_MOV: begin
        res   = rs_val;
        wr_en = 1'b1;
      end
      OP_LDI: begin
        res   = DW'(imm8);
        wr_en = 1'b1;
      end
      OP_ADD, OP_ADC: begin
        res    = sum[DW-1:0];
        wr_en  = 1'b1;
        upd_nz = 1'b1;
        c_new  = sum[DW];
        v_new  = (rd_val[DW-1] == rs_val[DW-1]) && (sum[DW-1] != rd_val[DW-1]);
      end
      OP_AND: begin
        res    = rd_val & rs_val;
        wr_en  = 1'b1;
        upd_nz = 1'b1;
        v_new  = 1'b0;
      end
      OP_OR: begin
        res    = rd_val | rs_val;
        wr_en  = 1'b1;
        upd_nz = 1'b1;
        v_new  = 1'b0;
      end
      OP_BREQ: br_taken = sreg_q[0];
      OP_RJMP: br_taken = 1'b1;
      default: ;
    endcase
    z_new    = upd_nz ? (res == '0) : sreg_q[0];
    n_new    = upd_nz ? res[DW-1]   : sreg_q[2];
    sreg_new = {v_new, n_new, c_new, z_new};
    ip_next  = br_taken ? (ip_q + AW'($signed(imm8))) : (ip_q + AW'(1));
  end

  // Next-state logic for the instruction cycle and architectural state
  always_comb begin
    state_d   = state_q;
    started_d = 1'b1;
    ip_d      = ip_q;
    ir_d      = ir_q;
    sreg_d    = sreg_q;
    case (state_q)
      S_FETCH: begin
        if (started_q && imem_valid) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        sreg_d  = sreg_new;
        ip_d    = ip_next;
        state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  // Register-file next value; out-of-range destinations are dropped
  always_comb begin
    regs_d = regs_q;
    if (state_q == S_EXEC && wr_en) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (rd_idx == 4'(i)) regs_d[i] = res;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      started_q <= 1'b0;
      ip_q      <= '0;
      ir_q      <= '0;
      sreg_q    <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      ip_q      <= ip_d;
      ir_q      <= ir_d;
      sreg_q    <= sreg_d;
      regs_q    <= regs_d;
    end
  end

  // started_q keeps FETCH from requesting until the first edge after reset
  assign imem_req  = started_q && (state_q == S_FETCH);
  assign imem_addr = ip_q;
  assign sreg      = sreg_q;
  assign halted    = (state_q == S_HALT);

  // Debug read port; indices beyond NREG read as zero
  always_comb begin
    dbg_data = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (dbg_idx == 4'(i)) dbg_data = regs_q[i];
    end
  end

endmodule
